// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared types, sprite defaults and respawn helpers for the enemy fleet
package enemy_pkg;

  typedef enum logic [1:0] {
    FALL    = 2'd0,
    EXPLODE = 2'd1,
    DEAD    = 2'd2
  } slot_state_e;

  localparam int SPRITE_W_DEF = 50;
  localparam int SPRITE_H_DEF = 50;

  // Next respawn column: advance by x_step, wrap back to x_min once the sprite would leave the screen.
  function automatic logic [9:0] respawn_x(input logic [9:0] cur_x, input int x_min,
                                           input int x_step, input int x_max);
    logic [10:0] nx;
    logic [9:0]  res;
    nx = {1'b0, cur_x} + 11'(x_step);
    if (nx > 11'(x_max)) res = 10'(x_min);
    else                 res = nx[9:0];
    return res;
  endfunction

  // Reset column of slot idx: x_min stepped idx times through the respawn rule.
  function automatic logic [9:0] init_x(input int idx, input int x_min,
                                        input int x_step, input int x_max);
    logic [9:0] xv;
    xv = 10'(x_min);
    for (int i = 0; i < idx; i++) xv = respawn_x(xv, x_min, x_step, x_max);
    return xv;
  endfunction

endpackage

// File: rtl/enemy_slot.sv
// rtl/enemy_slot.sv - one enemy plane: fall/explode/dead FSM, explosion counter and position
module enemy_slot
  import enemy_pkg::*;
#(
  parameter int         SCREEN_W   = 640,
  parameter int         SPRITE_W   = SPRITE_W_DEF,
  parameter int         Y_LIMIT    = 430,
  parameter int         X_MIN      = 120,
  parameter int         X_STEP     = 100,
  parameter int         BOOM_TICKS = 255,
  parameter logic [9:0] INIT_X     = 10'd120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic       boom,
  input  logic       revive,
  input  logic [2:0] step,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       alive,
  output logic       visible,
  output logic       exploding,
  output logic       kill_now
);

  localparam int          X_MAX    = SCREEN_W - SPRITE_W;
  localparam logic [10:0] Y_LIM11  = 11'(Y_LIMIT);
  localparam logic [7:0]  BOOM_END = 8'(BOOM_TICKS);

  slot_state_e state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] y_stepped;
  logic [9:0]  x_resp;
  logic [7:0]  cnt_inc;

  assign y_stepped = {1'b0, y_q} + {8'd0, step};
  assign x_resp    = respawn_x(x_q, X_MIN, X_STEP, X_MAX);
  assign cnt_inc   = cnt_q + 8'd1;

  // State, position and explosion counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FALL;
      x_q     <= INIT_X;
      y_q     <= 10'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and datapath; nothing moves except on a motion tick.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    if (move_tick) begin
      case (state_q)
        FALL: begin
          if (boom) begin
            state_d = EXPLODE;
            cnt_d   = 8'd1;
          end else if (revive || (y_stepped >= Y_LIM11)) begin
            x_d = x_resp;
            y_d = 10'd0;
          end else begin
            y_d = y_stepped[9:0];
          end
        end
        EXPLODE: begin
          cnt_d = cnt_inc;
          if (cnt_inc == BOOM_END) state_d = DEAD;
        end
        DEAD: begin
          if (revive) begin
            state_d = FALL;
            x_d     = x_resp;
            y_d     = 10'd0;
          end
        end
        default: state_d = FALL;
      endcase
    end
  end

  // Status decode for the fleet-level scoring and pixel logic.
  always_comb begin
    alive     = (state_q == FALL);
    visible   = (state_q != DEAD);
    exploding = (state_q == EXPLODE);
    kill_now  = move_tick && boom && (state_q == FALL);
  end

  assign pos_x = x_q;
  assign pos_y = y_q;

endmodule

// File: rtl/enemy_fleet_ctrl.sv
// rtl/enemy_fleet_ctrl.sv - N-slot enemy fleet: slot array, kill scoring, pixel owner mux; SPEED_RAMP_EN enables kill-based fall speed
module enemy_fleet_ctrl
  import enemy_pkg::*;
#(
  parameter int N_ENEMY    = 4,
  parameter int SPRITE_W   = SPRITE_W_DEF,
  parameter int SPRITE_H   = SPRITE_H_DEF,
  parameter int SCREEN_W   = 640,
  parameter int Y_LIMIT    = 430,
  parameter int X_MIN      = 120,
  parameter int X_STEP     = 100,
  parameter int BOOM_TICKS = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   move_tick,
  input  logic [N_ENEMY-1:0]     boom,
  input  logic [N_ENEMY-1:0]     revive,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  output logic [10*N_ENEMY-1:0]  enemy_x,
  output logic [10*N_ENEMY-1:0]  enemy_y,
  output logic [N_ENEMY-1:0]     alive,
  output logic                   pix_en,
  output logic [2:0]             pix_slot,
  output logic                   pix_boom,
  output logic [11:0]            pix_addr,
  output logic                   kill_pulse,
  output logic [15:0]            kill_count
);

  localparam logic [9:0]  SW10 = 10'(SPRITE_W);
  localparam logic [9:0]  SH10 = 10'(SPRITE_H);
  localparam logic [11:0] SW12 = 12'(SPRITE_W);

  logic [N_ENEMY-1:0] visible, exploding, kill_now, hit;
  logic [9:0]         dx [N_ENEMY];
  logic [9:0]         dy [N_ENEMY];
  logic [2:0]         step;
  logic [3:0]         kill_pc;
  logic [16:0]        kc_sum;
  logic               hit_en, hit_boom;
  logic [2:0]         hit_slot;
  logic [11:0]        hit_addr;

`ifdef SPEED_RAMP_EN
  // Fall speed grows by one pixel per 16 kills, capped at four.
  always_comb begin
    step = 3'd1 + {1'b0, ((kill_count[15:6] != 10'd0) ? 2'd3 : kill_count[5:4])};
  end
`else
  assign step = 3'd1;
`endif

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_slot
    enemy_slot #(
      .SCREEN_W  (SCREEN_W),
      .SPRITE_W  (SPRITE_W),
      .Y_LIMIT   (Y_LIMIT),
      .X_MIN     (X_MIN),
      .X_STEP    (X_STEP),
      .BOOM_TICKS(BOOM_TICKS),
      .INIT_X    (init_x(i, X_MIN, X_STEP, SCREEN_W - SPRITE_W))
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .move_tick(move_tick),
      .boom     (boom[i]),
      .revive   (revive[i]),
      .step     (step),
      .pos_x    (enemy_x[10*i +: 10]),
      .pos_y    (enemy_y[10*i +: 10]),
      .alive    (alive[i]),
      .visible  (visible[i]),
      .exploding(exploding[i]),
      .kill_now (kill_now[i])
    );

    // Unsigned offsets wrap for pixels left of/above the box, so one compare bounds both sides.
    assign dx[i]  = x - enemy_x[10*i +: 10];
    assign dy[i]  = y - enemy_y[10*i +: 10];
    assign hit[i] = (dx[i] < SW10) && (dy[i] < SH10) && visible[i];
  end

  // Number of slots that entered EXPLODE on this tick.
  always_comb begin
    kill_pc = 4'd0;
    for (int i = 0; i < N_ENEMY; i++) kill_pc = kill_pc + {3'd0, kill_now[i]};
  end

  assign kc_sum = {1'b0, kill_count} + {13'd0, kill_pc};

  // Kill pulse and saturating kill total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kill_pulse <= 1'b0;
      kill_count <= 16'd0;
    end else begin
      kill_pulse <= |kill_now;
      kill_count <= kc_sum[16] ? 16'hFFFF : kc_sum[15:0];
    end
  end

  // Pixel owner: scan from the top index down so the lowest hit index ends up winning.
  always_comb begin
    hit_en   = 1'b0;
    hit_slot = 3'd0;
    hit_boom = 1'b0;
    hit_addr = 12'd0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_en   = 1'b1;
        hit_slot = 3'(i);
        hit_boom = exploding[i];
        hit_addr = {2'b00, dx[i]} + ({2'b00, dy[i]} * SW12);
      end
    end
  end

  // Registered pixel outputs feeding the external sprite ROM stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_en   <= 1'b0;
      pix_slot <= 3'd0;
      pix_boom <= 1'b0;
      pix_addr <= 12'd0;
    end else begin
      pix_en   <= hit_en;
      pix_slot <= hit_slot;
      pix_boom <= hit_boom;
      pix_addr <= hit_addr;
    end
  end

endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// tb/tb_enemy_fleet_ctrl.sv - scoreboard bench for enemy_fleet_ctrl (default build, N_ENEMY=4)
module tb_enemy_fleet_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        move_tick = 1'b0;
  logic [3:0]  boom = 4'd0;
  logic [3:0]  revive = 4'd0;
  logic [9:0]  x = 10'd1000;
  logic [9:0]  y = 10'd1000;
  logic [39:0] enemy_x, enemy_y;
  logic [3:0]  alive;
  logic        pix_en, pix_boom, kill_pulse;
  logic [2:0]  pix_slot;
  logic [11:0] pix_addr;
  logic [15:0] kill_count;

  always #5 clk = ~clk;

  enemy_fleet_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .move_tick (move_tick),
    .boom      (boom),
    .revive    (revive),
    .x         (x),
    .y         (y),
    .enemy_x   (enemy_x),
    .enemy_y   (enemy_y),
    .alive     (alive),
    .pix_en    (pix_en),
    .pix_slot  (pix_slot),
    .pix_boom  (pix_boom),
    .pix_addr  (pix_addr),
    .kill_pulse(kill_pulse),
    .kill_count(kill_count)
  );

  typedef struct {
    int          code;
    logic [39:0] exp;
    string       name;
  } exp_t;

  exp_t        sq[$];
  logic [15:0] kq[$];
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic logic [39:0] p4(input int a3, input int a2, input int a1, input int a0);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  function automatic logic [39:0] actual(input int code);
    case (code)
      0:       return enemy_x;
      1:       return enemy_y;
      2:       return 40'(alive);
      3:       return 40'(kill_count);
      4:       return 40'(pix_en);
      5:       return 40'(pix_slot);
      6:       return 40'(pix_boom);
      7:       return 40'(pix_addr);
      default: return 40'd0;
    endcase
  endfunction

  task automatic expect_v(input int code, input logic [39:0] v, input string nm);
    exp_t e;
    e.code = code;
    e.exp  = v;
    e.name = nm;
    sq.push_back(e);
  endtask

  task automatic tick(input logic [3:0] b, input logic [3:0] r);
    @(negedge clk);
    boom = b;
    revive = r;
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    boom = 4'd0;
    revive = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (sq.size() == 0 && kq.size() == 0) return;
      @(negedge clk);
    end
    n_vec++;
    n_miss++;
    $display("FAIL drain: %0d checks and %0d kill pulses still pending, required 0", sq.size(), kq.size());
    sq.delete();
    kq.delete();
  endtask

  // Monitor: samples after each rising edge, checks kill pulses and pending expectations.
  initial begin
    exp_t        e;
    logic [39:0] a;
    logic [15:0] k;
    forever begin
      @(posedge clk);
      #2;
      if (kill_pulse) begin
        n_vec++;
        if (kq.size() == 0) begin
          n_miss++;
          $display("FAIL kill_pulse_spurious: got pulse (kill_count=%0d), required no pulse", kill_count);
        end else begin
          k = kq.pop_front();
          if (kill_count !== k) begin
            n_miss++;
            $display("FAIL kill_count_at_pulse: got %0d, required %0d", kill_count, k);
          end
        end
      end
      while (sq.size() > 0) begin
        e = sq.pop_front();
        a = actual(e.code);
        n_vec++;
        if (a !== e.exp) begin
          n_miss++;
          $display("FAIL %s: got 'h%0h, required 'h%0h", e.name, a, e.exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    expect_v(0, p4(420, 320, 220, 120), "rst_enemy_x");
    expect_v(1, 40'd0, "rst_enemy_y");
    expect_v(2, 40'hF, "rst_alive");
    expect_v(3, 40'd0, "rst_kill_count");
    expect_v(4, 40'd0, "rst_pix_en");
    drain();

    repeat (429) tick(4'd0, 4'd0);
    expect_v(1, p4(429, 429, 429, 429), "y_at_429");
    expect_v(0, p4(420, 320, 220, 120), "x_before_escape");
    drain();
    tick(4'd0, 4'd0);
    expect_v(0, p4(520, 420, 320, 220), "escape_x");
    expect_v(1, 40'd0, "escape_y");
    drain();

    repeat (10) tick(4'd0, 4'd0);
    kq.push_back(16'd1);
    tick(4'b0010, 4'd0);
    expect_v(2, 40'b1101, "boom1_alive");
    expect_v(1, p4(11, 11, 10, 11), "boom1_y");
    drain();

    repeat (253) tick(4'b0010, 4'b0010);
    x = 10'd325;
    y = 10'd13;
    expect_v(4, 40'd1, "expl_pix_en");
    expect_v(5, 40'd1, "expl_pix_slot");
    expect_v(6, 40'd1, "expl_pix_boom");
    expect_v(7, 40'd155, "expl_pix_addr");
    expect_v(1, p4(264, 264, 10, 264), "expl_y_frozen");
    drain();

    tick(4'd0, 4'b0010);
    expect_v(4, 40'd0, "dead_pix_en");
    expect_v(7, 40'd0, "dead_pix_addr");
    expect_v(2, 40'b1101, "dead_alive");
    drain();
    tick(4'b0010, 4'd0);
    expect_v(2, 40'b1101, "dead_boom_ignored");
    drain();
    tick(4'd0, 4'b0010);
    expect_v(0, p4(520, 420, 420, 220), "revive_x");
    expect_v(1, p4(267, 267, 0, 267), "revive_y");
    expect_v(2, 40'hF, "revive_alive");
    drain();

    kq.push_back(16'd3);
    tick(4'b0101, 4'd0);
    expect_v(2, 40'b1010, "double_boom_alive");
    expect_v(3, 40'd3, "double_boom_count");
    drain();

    kq.push_back(16'd4);
    tick(4'b1000, 4'b1000);
    expect_v(0, p4(520, 420, 420, 220), "boom_revive_x");
    expect_v(2, 40'b0010, "boom_revive_alive");
    drain();
    tick(4'd0, 4'b0010);
    tick(4'd0, 4'b0010);
    expect_v(0, p4(520, 420, 120, 220), "wrap_x");
    expect_v(1, p4(268, 267, 0, 267), "wrap_y");
    drain();

    x = 10'd1000;
    y = 10'd1000;
    do_reset();
    expect_v(0, p4(420, 320, 220, 120), "rst2_enemy_x");
    expect_v(2, 40'hF, "rst2_alive");
    expect_v(3, 40'd0, "rst2_kill_count");
    drain();

    x = 10'd120;
    y = 10'd0;
    expect_v(4, 40'd1, "pix_origin_en");
    expect_v(5, 40'd0, "pix_origin_slot");
    expect_v(7, 40'd0, "pix_origin_addr");
    expect_v(6, 40'd0, "pix_origin_boom");
    drain();
    x = 10'd169;
    y = 10'd49;
    expect_v(4, 40'd1, "pix_corner_en");
    expect_v(7, 40'd2499, "pix_corner_addr");
    drain();
    x = 10'd170;
    y = 10'd0;
    expect_v(4, 40'd0, "pix_right_edge_en");
    drain();
    x = 10'd119;
    expect_v(4, 40'd0, "pix_left_wrap_en");
    expect_v(5, 40'd0, "pix_left_wrap_slot");
    expect_v(7, 40'd0, "pix_left_wrap_addr");
    drain();

    x = 10'd1000;
    y = 10'd1000;
    tick(4'd0, 4'b0001);
    repeat (4) tick(4'd0, 4'b0011);
    expect_v(0, p4(420, 320, 120, 120), "overlap_x");
    expect_v(1, p4(5, 5, 0, 0), "overlap_y");
    drain();
    x = 10'd130;
    y = 10'd2;
    expect_v(4, 40'd1, "overlap_pix_en");
    expect_v(5, 40'd0, "overlap_pix_slot");
    expect_v(7, 40'd110, "overlap_pix_addr");
    drain();
    kq.push_back(16'd1);
    tick(4'b0001, 4'd0);
    expect_v(5, 40'd0, "overlap_expl_slot");
    expect_v(6, 40'd1, "overlap_expl_boom");
    expect_v(7, 40'd110, "overlap_expl_addr");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
